// File: rtl/axi_ram_responder.sv
// ---------------------------------------------------------------------------
// axi_ram_responder
//
// AXI4 slave backed by an internal byte-strobed word RAM. It serves one write
// or read burst at a time and answers with the requester's ID on B and R.
// All bursts are treated as INCR with full-width beats. The word index wraps
// modulo the RAM depth, so a burst that runs off the top continues at word 0.
//
// Ports
//   aclk, reset        : clock (rising edge), asynchronous active-high reset
//   s_axi_aw*          : write address channel (id, addr, len used; the
//                        remaining attributes are accepted and ignored)
//   s_axi_w*           : write data channel (data, strobes, last)
//   s_axi_b*           : write response (id, resp = OKAY or SLVERR)
//   s_axi_ar*          : read address channel (id, addr, len used)
//   s_axi_r*           : read data channel (id, data, resp = OKAY, last)
// ---------------------------------------------------------------------------
module axi_ram_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int ID_WIDTH       = 8,
    parameter int MEM_WORDS_LOG2 = 10
) (
    input  logic                  aclk,
    input  logic                  reset,

    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,

    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,

    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,

    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,

    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int OFFS  = $clog2(STRB_WIDTH);
    localparam int DEPTH = 1 << MEM_WORDS_LOG2;
    localparam logic [MEM_WORDS_LOG2-1:0] IDX_ONE = 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WRESP = 2'd2,
        READ  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [ID_WIDTH-1:0]       id_q, id_d;
    logic [MEM_WORDS_LOG2-1:0] index_q, index_d;
    // WRITE: beats still to accept after the current one.
    // READ : beats still to fetch from the RAM.
    logic [7:0]                beats_q, beats_d;
    logic                      err_q, err_d;
    logic                      last_was_read_q, last_was_read_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      rvalid_q, rvalid_d;
    logic                      rlast_q, rlast_d;

    logic [DATA_WIDTH-1:0]     mem [0:DEPTH-1];
    logic                      mem_we;
    logic [MEM_WORDS_LOG2-1:0] aw_index, ar_index, rd_index;
    logic [DATA_WIDTH-1:0]     rd_word;
    logic                      aw_ready, ar_ready;

    assign aw_index = s_axi_awaddr[MEM_WORDS_LOG2+OFFS-1:OFFS];
    assign ar_index = s_axi_araddr[MEM_WORDS_LOG2+OFFS-1:OFFS];

    // The first read beat is fetched on the AR handshake edge so rvalid rises
    // the following cycle; after that the running index addresses the RAM.
    assign rd_index = (state_q == IDLE) ? ar_index : index_q;
    assign rd_word  = mem[rd_index];

    // Address channel arbitration. When both requests are pending the grant
    // alternates, starting with the write after reset. Ready is gated with
    // reset so nothing can handshake while the block is held in reset.
    always_comb begin
        aw_ready = 1'b0;
        ar_ready = 1'b0;
        if (state_q == IDLE && !reset) begin
            aw_ready = s_axi_awvalid && (!s_axi_arvalid || last_was_read_q);
            ar_ready = s_axi_arvalid && !aw_ready;
        end
    end

    // NOTE: every variable gets its default before the case statement, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d         = state_q;
        id_d            = id_q;
        index_d         = index_q;
        beats_d         = beats_q;
        err_d           = err_q;
        last_was_read_d = last_was_read_q;
        rdata_d         = rdata_q;
        rvalid_d        = rvalid_q;
        rlast_d         = rlast_q;
        mem_we          = 1'b0;

        case (state_q)
            IDLE: begin
                if (aw_ready) begin
                    id_d            = s_axi_awid;
                    index_d         = aw_index;
                    beats_d         = s_axi_awlen;
                    err_d           = 1'b0;
                    last_was_read_d = 1'b0;
                    state_d         = WRITE;
                end else if (ar_ready) begin
                    id_d            = s_axi_arid;
                    rdata_d         = rd_word;
                    rvalid_d        = 1'b1;
                    rlast_d         = (s_axi_arlen == 8'd0);
                    index_d         = ar_index + IDX_ONE;
                    beats_d         = s_axi_arlen;
                    last_was_read_d = 1'b1;
                    state_d         = READ;
                end
            end

            WRITE: begin
                if (s_axi_wvalid) begin
                    mem_we  = 1'b1;
                    index_d = index_q + IDX_ONE;
                    beats_d = beats_q - 8'd1;
                    // The burst ends by count; a misplaced wlast only flags it.
                    if (s_axi_wlast != (beats_q == 8'd0)) begin
                        err_d = 1'b1;
                    end
                    if (beats_q == 8'd0) begin
                        state_d = WRESP;
                    end
                end
            end

            WRESP: begin
                if (s_axi_bready) begin
                    state_d = IDLE;
                end
            end

            READ: begin
                if (rvalid_q && s_axi_rready && rlast_q) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    state_d  = IDLE;
                end else if ((!rvalid_q || s_axi_rready) && beats_q != 8'd0) begin
                    // Refill the output register only when its beat has gone,
                    // so a stalled beat is neither skipped nor repeated.
                    rdata_d  = rd_word;
                    rvalid_d = 1'b1;
                    rlast_d  = (beats_q == 8'd1);
                    index_d  = index_q + IDX_ONE;
                    beats_d  = beats_q - 8'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            id_q            <= '0;
            index_q         <= '0;
            beats_q         <= '0;
            err_q           <= 1'b0;
            last_was_read_q <= 1'b1;
            rdata_q         <= '0;
            rvalid_q        <= 1'b0;
            rlast_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            id_q            <= id_d;
            index_q         <= index_d;
            beats_q         <= beats_d;
            err_q           <= err_d;
            last_was_read_q <= last_was_read_d;
            rdata_q         <= rdata_d;
            rvalid_q        <= rvalid_d;
            rlast_q         <= rlast_d;
        end
    end

    // NOTE: the RAM array has no reset; contents survive reset and clearing
    // it would prevent mapping onto memory primitives.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[index_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign s_axi_awready = aw_ready;
    assign s_axi_arready = ar_ready;
    assign s_axi_wready  = (state_q == WRITE);
    assign s_axi_bvalid  = (state_q == WRESP);
    assign s_axi_bid     = id_q;
    assign s_axi_bresp   = err_q ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rid     = id_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RESP_OKAY;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;

    // Burst attributes outside the supported subset are accepted and ignored.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awaddr, s_axi_awsize, s_axi_awburst,
                             s_axi_awlock, s_axi_awcache, s_axi_awprot,
                             s_axi_araddr, s_axi_arsize, s_axi_arburst,
                             s_axi_arlock, s_axi_arcache, s_axi_arprot};

endmodule

// File: doc/axi_ram_responder.md
# axi_ram_responder

AXI4 memory responder that serves the master-side AXI port of the stream-to-AXI crossbar in simulation benches and small FPGA builds without external DRAM. It accepts one write or read burst at a time, backs it with an internal byte-strobed word RAM, and returns B and R responses with the requester's ID. It is the slave-side counterpart of the crossbar's memory port and connects to it signal for signal.

## Interface
- DATA_WIDTH, 32, data bus width in bits
- ADDR_WIDTH, 32, AXI address width
- STRB_WIDTH, 4, byte lanes (DATA_WIDTH/8)
- ID_WIDTH, 8, AXI ID width
- MEM_WORDS_LOG2, 10, log2 of RAM depth in DATA_WIDTH words
- aclk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- s_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/1  write address channel
- s_axi_awready  out  1
- s_axi_wdata/wstrb/wlast/wvalid  in  DATA_WIDTH/STRB_WIDTH/1/1  write data; s_axi_wready  out  1
- s_axi_bid/bresp/bvalid  out  ID_WIDTH/2/1; s_axi_bready  in  1
- s_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  in  as AW channel; s_axi_arready  out  1
- s_axi_rid/rdata/rresp/rlast/rvalid  out  ID_WIDTH/DATA_WIDTH/2/1/1; s_axi_rready  in  1

## Operation
- FSM states: IDLE, WRITE, WRESP, READ. Reset -> IDLE.
- Reset value of every output: awready, wready, bvalid, arready, rvalid, rlast = 0; bid, rid, rdata = 0; bresp, rresp = 2'b00. RAM contents are not cleared.
- IDLE arbitration: awready = awvalid && (!arvalid || lastWasRead); arready = arvalid && !awready. Both requests pending alternate; lastWasRead resets to 1 (write wins first tie).
- AW handshake: capture awid, word index = awaddr[MEM_WORDS_LOG2+log2(STRB_WIDTH)-1 : log2(STRB_WIDTH)], beatsLeft = awlen; clear errFlag; -> WRITE.
- WRITE: wready = 1. Each W handshake writes wdata to RAM[index] per byte under wstrb, index <= index+1 (wraps modulo 2^MEM_WORDS_LOG2). Last beat is the beat where beatsLeft == 0; errFlag set if wlast != (beatsLeft == 0) on any beat. After last beat -> WRESP.
- WRESP: bvalid = 1, bid = captured id, bresp = errFlag ? 2'b10 (SLVERR) : 2'b00. Hold until bready -> IDLE. Termination is by count only; beats after a premature wlast still belong to the current burst.
- AR handshake: capture arid, index, beatsLeft = arlen -> READ.
- READ: rdata register loads RAM[index] when (!rvalid || rready) and beats remain to fetch; rvalid held until rready. rlast = 1 on the final beat; rresp = 2'b00; rid = captured id. Last beat accepted (rvalid && rready && rlast) -> IDLE, rvalid drops same edge.
- awsize/arsize ignored (full-width beats); awburst/arburst treated as INCR; lock/cache/prot ignored.
- Reset asserted mid-burst: FSM to IDLE immediately, all handshake outputs low, partially written data stays in RAM.

## Timing
- AW/AR ready combinational from valid and state in IDLE only; never asserted outside IDLE.
- wready high from cycle after AW handshake; one beat per cycle sustained.
- bvalid high the cycle after the last W handshake.
- First rvalid one cycle after AR handshake; with rready held high, one beat per cycle, burst of N beats ends N cycles after first rvalid.
- rready low: rdata/rlast/rvalid stable until accepted (no beat skipped or repeated).
- Turnaround: next AW/AR accepted earliest the cycle after B or final R handshake.
- 256-beat burst (len 255) and index wrap from 2^MEM_WORDS_LOG2-1 to 0 within a burst are legal.

## Test plan
- Write awaddr 0x10, awlen 3, id 0x5A, data 0x11111111..0x44444444, wstrb 0xF -> wready follows, bvalid 1 cycle after 4th beat, bid 0x5A, bresp 0; read back arlen 3 -> rdata same sequence, rlast on 4th, rid matches, first rvalid 1 cycle after AR.
- Partial strobe: write 0xAABBCCDD to 0x0 with wstrb 0x5 over prior 0x00000000 -> readback 0x00BB00DD.
- Read with rready toggling 1,0,0,1,... over 8 beats -> all 8 words in order, no duplicates, rdata stable while stalled.
- awvalid and arvalid asserted together twice -> write granted first, read second; neither starved.
- awlen 3 with wlast on beat 2 -> 4 beats consumed, bresp 2'b10; wrap burst at index 1022, len 3 -> words 1022,1023,0,1 written.
- Assert reset during beat 2 of an 8-beat read -> rvalid/arready/awready 0 asynchronously; after release, new AW accepted and completes normally.
